jk_bank_driver: RTL and testbench

Initiator that drives a bank of WIDTH JK flip-flops to a requested target word. It accepts one request per transaction on a valid/ready handshake and computes per-bit J/K excitation from the target and the bank's live `q` feedback. It then pulses the excitation for one cycle, reads back the bank, and re-drives until the bank matches or the retry budget runs out. It sits between control logic and any JK register bank in the design.

---
 rtl/jk_pkg.sv | 34 +++
 rtl/jk_excite.sv | 23 ++
 rtl/jk_bank_driver.sv | 132 +++++++++++++
 tb/tb_jk_bank_driver.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// jk_pkg: shared types and constants for the JK bank driver.
// Holds the driver FSM state type, JK command encodings, mode codes.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_IDLE  = 2'd0,
    JK_DRIVE = 2'd1,
    JK_CHECK = 2'd2
  } jk_drv_state_t;

  // {J,K} command per bit
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  localparam logic JK_MODE_SR  = 1'b0;
  localparam logic JK_MODE_TGL = 1'b1;

  function automatic logic [1:0] jk_cmd(
    input logic t,
    input logic q,
    input logic mode
  );
    logic [1:0] c;
    c = JK_HOLD;
    if (t != q) begin
      if (mode == JK_MODE_TGL) c = JK_TGL;
      else c = t ? JK_SET : JK_RST;
    end
    return c;
  endfunction

endpackage

// File: rtl/jk_excite.sv
// jk_excite: combinational per-word J/K excitation from target and q.
// Ports: target, q, mode in; j, k out.
module jk_excite
  import jk_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] q,
  input  logic             mode,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  always_comb begin
    j = '0;
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {j[i], k[i]} = jk_cmd(target[i], q[i], mode);
    end
  end

endmodule

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: drives a JK flop bank to a target word with readback/retry.
// Ports: req_* handshake in, j_out/k_out to bank, q_in feedback, done_* result.
module jk_bank_driver
  import jk_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int MAX_RETRY = 3,
  localparam int RW        = $clog2(MAX_RETRY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic             req_mode,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  input  logic [WIDTH-1:0] q_in,
  output logic             done_valid,
  output logic             done_err,
  output logic [RW-1:0]    done_retries
);

  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);

  jk_drv_state_t    state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             mode_q, mode_d;
  logic [RW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             dv_q, dv_d;
  logic             de_q, de_d;
  logic [RW-1:0]    dr_q, dr_d;

  logic [WIDTH-1:0] ex_tgt;
  logic             ex_mode;
  logic [WIDTH-1:0] ex_j;
  logic [WIDTH-1:0] ex_k;

  // One excitation unit: request word while idle, latched target otherwise.
  assign ex_tgt  = (state_q == JK_IDLE) ? req_data : tgt_q;
  assign ex_mode = (state_q == JK_IDLE) ? req_mode : mode_q;

  jk_excite #(.WIDTH(WIDTH)) u_excite (
    .target (ex_tgt),
    .q      (q_in),
    .mode   (ex_mode),
    .j      (ex_j),
    .k      (ex_k)
  );

  assign req_ready    = (state_q == JK_IDLE);
  assign j_out        = j_q;
  assign k_out        = k_q;
  assign done_valid   = dv_q;
  assign done_err     = de_q;
  assign done_retries = dr_q;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    j_d     = '0;
    k_d     = '0;
    dv_d    = 1'b0;
    de_d    = de_q;
    dr_d    = dr_q;
    unique case (1'b1)
      (state_q == JK_IDLE): begin
        if (req_valid) begin
          tgt_d   = req_data;
          mode_d  = req_mode;
          cnt_d   = '0;
          j_d     = ex_j;
          k_d     = ex_k;
          state_d = JK_DRIVE;
        end
      end
      (state_q == JK_DRIVE): begin
        state_d = JK_CHECK;
      end
      (state_q == JK_CHECK): begin
        if (q_in == tgt_q) begin
          dv_d    = 1'b1;
          de_d    = 1'b0;
          dr_d    = cnt_q;
          state_d = JK_IDLE;
        end else if (cnt_q < MAX_R) begin
          cnt_d   = cnt_q + 1'b1;
          j_d     = ex_j;
          k_d     = ex_k;
          state_d = JK_DRIVE;
        end else begin
          dv_d    = 1'b1;
          de_d    = 1'b1;
          dr_d    = MAX_R;
          state_d = JK_IDLE;
        end
      end
      default: begin
        state_d = JK_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= JK_IDLE;
      tgt_q   <= '0;
      mode_q  <= JK_MODE_SR;
      cnt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      dv_q    <= 1'b0;
      de_q    <= 1'b0;
      dr_q    <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      dv_q    <= dv_d;
      de_q    <= de_d;
      dr_q    <= dr_d;
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// tb_jk_bank_driver: directed stimulus with a JK bank model and scoreboard.
// Expected excitations/completions are queued; a negedge monitor compares.
module tb_jk_bank_driver;

  localparam int W  = 8;
  localparam int MR = 3;
  localparam int RW = 2;

  typedef struct {
    logic          err;
    logic [RW-1:0] ret;
    int            lat;
  } done_t;

  typedef struct {
    logic [W-1:0] j;
    logic [W-1:0] k;
  } exc_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  req_data = '0;
  logic          req_mode = 1'b0;
  logic [W-1:0]  j_out;
  logic [W-1:0]  k_out;
  logic [W-1:0]  q_in;
  logic          done_valid;
  logic          done_err;
  logic [RW-1:0] done_retries;

  done_t done_q[$];
  exc_t  exc_q[$];
  int    acc_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;

  logic [W-1:0] bank = '0;
  logic [W-1:0] stuck = '0;
  logic         ign = 1'b0;
  logic         ld = 1'b0;
  logic [W-1:0] ld_v = '0;
  logic [W-1:0] ld_stuck = '0;
  logic         ld_ign = 1'b0;

  always #5 clk = ~clk;

  jk_bank_driver #(.WIDTH(W), .MAX_RETRY(MR)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .req_mode     (req_mode),
    .j_out        (j_out),
    .k_out        (k_out),
    .q_in         (q_in),
    .done_valid   (done_valid),
    .done_err     (done_err),
    .done_retries (done_retries)
  );

  assign q_in = bank;

  always @(posedge clk) cyc <= cyc + 1;

  // JK bank: optional stuck-at-0 bits, optional ignore of one drive pulse
  always @(posedge clk) begin
    if (ld) begin
      bank  <= ld_v;
      stuck <= ld_stuck;
      ign   <= ld_ign;
    end else if (ign && ((j_out | k_out) != '0)) begin
      ign <= 1'b0;
    end else begin
      bank <= ((j_out & ~bank) | (~k_out & bank)) & ~stuck;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exc_t e;
    done_t d;
    int lat;
    logic nz;
    static logic prev_nz = 1'b0;
    if (!rst_n) acc_q.delete();
    nz = ((j_out | k_out) != '0);
    if (nz) begin
      chk("exc_single_cycle", 32'(prev_nz), 32'd0);
      if (exc_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_exc: j=%0h k=%0h", j_out, k_out);
      end else begin
        e = exc_q.pop_front();
        chk("j_out", 32'(j_out), 32'(e.j));
        chk("k_out", 32'(k_out), 32'(e.k));
      end
    end
    prev_nz = nz;
    if (done_valid) begin
      if (done_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: err=%0b ret=%0d", done_err,
                 done_retries);
      end else begin
        d = done_q.pop_front();
        lat = (acc_q.size() > 0) ? cyc - acc_q.pop_front() : -1;
        chk("done_err", 32'(done_err), 32'(d.err));
        chk("done_retries", 32'(done_retries), 32'(d.ret));
        chk("latency", lat, d.lat);
      end
    end
    if (rst_n && req_valid && req_ready) acc_q.push_back(cyc);
  end

  task automatic set_bank(input logic [W-1:0] v, input logic [W-1:0] s,
                          input logic ig);
    ld       = 1'b1;
    ld_v     = v;
    ld_stuck = s;
    ld_ign   = ig;
    @(posedge clk);
    #1 ld = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input logic m,
                      output int acc);
    acc       = -1;
    req_valid = 1'b1;
    req_data  = d;
    req_mode  = m;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (acc < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: data=%0h", d);
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_valid) begin
        seen = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: no done_valid");
    end
  endtask

  task automatic push_exc(input logic [W-1:0] j, input logic [W-1:0] k,
                          input int n);
    exc_t e;
    e.j = j;
    e.k = k;
    for (int i = 0; i < n; i++) exc_q.push_back(e);
  endtask

  task automatic push_done(input logic err, input logic [RW-1:0] ret,
                           input int lat);
    done_t d;
    d.err = err;
    d.ret = ret;
    d.lat = lat;
    done_q.push_back(d);
  endtask

  task automatic run(input logic [W-1:0] d, input logic m, input logic err,
                     input logic [RW-1:0] ret, input int lat);
    int a;
    push_done(err, ret, lat);
    send(d, m, a);
    req_valid = 1'b0;
    wait_done();
  endtask

  initial begin : stim
    int a1;
    int a2;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_j_out", 32'(j_out), 32'd0);
    chk("rst_k_out", 32'(k_out), 32'd0);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_done_err", 32'(done_err), 32'd0);
    chk("rst_done_retries", 32'(done_retries), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // set/reset drive
    set_bank(8'h00, 8'h00, 1'b0);
    push_exc(8'hA5, 8'h00, 1);
    run(8'hA5, 1'b0, 1'b0, 2'd0, 3);
    chk("bank_sr", 32'(bank), 32'hA5);

    // toggle drive
    set_bank(8'hF0, 8'h00, 1'b0);
    push_exc(8'hFF, 8'hFF, 1);
    run(8'h0F, 1'b1, 1'b0, 2'd0, 3);
    chk("bank_tgl", 32'(bank), 32'h0F);

    // stuck bit 3: first drive plus three retries
    set_bank(8'h00, 8'h08, 1'b0);
    push_exc(8'h08, 8'h00, 4);
    run(8'h08, 1'b0, 1'b1, 2'd3, 9);
    @(posedge clk);
    #1;
    chk("hold_done_err", 32'(done_err), 32'd1);
    chk("hold_done_retries", 32'(done_retries), 32'd3);
    chk("hold_done_valid", 32'(done_valid), 32'd0);

    // transient drop, mode 0
    set_bank(8'h00, 8'h00, 1'b1);
    push_exc(8'h3C, 8'h00, 2);
    run(8'h3C, 1'b0, 1'b0, 2'd1, 5);
    chk("bank_transient", 32'(bank), 32'h3C);

    // transient drop, mode 1: toggle re-issued from live q
    set_bank(8'h00, 8'h00, 1'b1);
    push_exc(8'h81, 8'h81, 2);
    run(8'h81, 1'b1, 1'b0, 2'd1, 5);
    chk("bank_tgl_retry", 32'(bank), 32'h81);

    // target already matches: no excitation, still completes
    set_bank(8'h5A, 8'h00, 1'b0);
    run(8'h5A, 1'b1, 1'b0, 2'd0, 3);
    chk("bank_match", 32'(bank), 32'h5A);

    // back-to-back: 0x11 then 0x22 (bank 0x11 -> J=0x22, K=0x11)
    set_bank(8'h00, 8'h00, 1'b0);
    push_exc(8'h11, 8'h00, 1);
    push_exc(8'h22, 8'h11, 1);
    push_done(1'b0, 2'd0, 3);
    push_done(1'b0, 2'd0, 3);
    send(8'h11, 1'b0, a1);
    req_data = 8'h22;
    send(8'h22, 1'b0, a2);
    req_valid = 1'b0;
    chk("b2b_gap", a2 - a1, 3);
    wait_done();
    chk("bank_b2b", 32'(bank), 32'h22);

    // reset during DRIVE
    set_bank(8'h00, 8'h00, 1'b0);
    push_exc(8'hFF, 8'h00, 1);
    send(8'hFF, 1'b0, a1);
    req_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_j_out", 32'(j_out), 32'd0);
    chk("async_k_out", 32'(k_out), 32'd0);
    chk("async_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(done_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    chk("bank_held", 32'(bank), 32'h00);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    push_exc(8'h42, 8'h00, 1);
    run(8'h42, 1'b0, 1'b0, 2'd0, 3);
    chk("bank_post_rst", 32'(bank), 32'h42);

    repeat (3) @(posedge clk);
    #1;
    chk("exc_queue_empty", exc_q.size(), 32'd0);
    chk("done_queue_empty", done_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
